// File: rtl/inst_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : inst_buffer_pkg                                           |
// | Purpose  : Shared pipeline types and constants for the inst buffer.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package inst_buffer_pkg;

    localparam int IBUF_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } inst_t;

    typedef enum logic [1:0] {
        ISSUE_NONE = 2'b00,
        ISSUE_ONE  = 2'b01,
        ISSUE_TWO  = 2'b10,
        ISSUE_BAD  = 2'b11
    } issue_e;

    function automatic logic [1:0] popcnt2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : inst_buffer_if                                            |
// | Purpose  : Frontend push / backend issue bundle of the inst buffer.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface inst_buffer_if;
    import inst_buffer_pkg::*;

    logic        flush_i;
    inst_t [1:0] inst_i;
    logic [1:0]  push_valid_i;
    logic        push_ready_o;
    inst_t [1:0] inst_o;
    logic [1:0]  inst_valid_o;
    logic [1:0]  issue_num_i;
    logic        backend_stall_i;

    modport slave (
        input  flush_i, inst_i, push_valid_i, issue_num_i, backend_stall_i,
        output push_ready_o, inst_o, inst_valid_o
    );

    modport master (
        output flush_i, inst_i, push_valid_i, issue_num_i, backend_stall_i,
        input  push_ready_o, inst_o, inst_valid_o
    );

endinterface
`default_nettype wire

// File: rtl/inst_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : inst_buffer                                               |
// | Purpose  : Two-in / two-out circular instruction buffer with flush.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = IBUF_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    inst_buffer_if.slave bus
);

    localparam int          PW          = $clog2(DEPTH);
    localparam logic [PW:0] C_READY_MAX = (PW+1)'(DEPTH - 2);

    logic [PW:0]   head_q, head_d;
    logic [PW:0]   tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    inst_t         mem_q [DEPTH];

    logic [PW-1:0] rd_idx0, rd_idx1, wr_idx0, wr_idx1;
    logic          push_ready, push_acc;
    logic [1:0]    valid, n_req, n_pop, n_push, n_avail;

    assign rd_idx0 = head_q[PW-1:0];
    assign rd_idx1 = head_q[PW-1:0] + PW'(1);
    assign wr_idx0 = tail_q[PW-1:0];
    assign wr_idx1 = tail_q[PW-1:0] + PW'(1);

    // Credit comes only from the registered count; a same-cycle pop never frees room.
    assign push_ready = (count_q <= C_READY_MAX);
    assign valid      = {count_q >= (PW+1)'(2), count_q >= (PW+1)'(1)};
    assign n_avail    = popcnt2(valid);
    assign push_acc   = push_ready & ~bus.flush_i;
    assign n_push     = push_acc ? popcnt2(bus.push_valid_i) : 2'd0;

    always_comb begin
        n_req = 2'd0;
        case (issue_e'(bus.issue_num_i))
            ISSUE_ONE: n_req = 2'd1;
            ISSUE_TWO: n_req = 2'd2;
            default:   n_req = 2'd0;
        endcase
        if (bus.backend_stall_i) begin
            n_req = 2'd0;
        end
        n_pop = (n_req > n_avail) ? n_avail : n_req;
    end

    always_comb begin
        head_d  = head_q + (PW+1)'(n_pop);
        tail_d  = tail_q + (PW+1)'(n_push);
        count_d = count_q + (PW+1)'(n_push) - (PW+1)'(n_pop);
        if (bus.flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Accepted lanes are compacted: a lone lane-1 push lands at tail.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            case (bus.push_valid_i)
                2'b01: mem_q[wr_idx0] <= bus.inst_i[0];
                2'b10: mem_q[wr_idx0] <= bus.inst_i[1];
                2'b11: begin
                    mem_q[wr_idx0] <= bus.inst_i[0];
                    mem_q[wr_idx1] <= bus.inst_i[1];
                end
                default: ;
            endcase
        end
    end

    assign bus.inst_o       = {mem_q[rd_idx1], mem_q[rd_idx0]};
    assign bus.inst_valid_o = valid;
    assign bus.push_ready_o = push_ready;

`ifndef SYNTHESIS
    a_issue_legal: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.issue_num_i != 2'b11) && (bus.issue_num_i <= n_avail));

    a_count_ptr: assert property (@(posedge clk) disable iff (!rst_n)
        count_q == (tail_q - head_q));
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_inst_buffer                                            |
// | Purpose  : Table, directed and random checks against a queue model.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int DEPTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    inst_buffer_if bus();

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    inst_t       model_q[$];
    int unsigned tag = 0;
    inst_t       last_a;

    typedef struct {
        logic       fl;
        logic [1:0] pv;
        logic [1:0] iss;
        logic       st;
        logic       exp_ready;
        logic [1:0] exp_valid;
    } vec_t;

    vec_t tbl [27];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic inst_t mk();
        inst_t r;
        tag++;
        r.pc    = tag * 4;
        r.instr = $urandom;
        return r;
    endfunction

    // Expected outputs come purely from the queue contents before the edge.
    task automatic check_model(input string where);
        int sz;
        sz = model_q.size();
        check({where, " ready"}, 64'(bus.push_ready_o), 64'((DEPTH - sz) >= 2));
        check({where, " valid"}, 64'(bus.inst_valid_o), 64'({sz >= 2, sz >= 1}));
        if (sz >= 1) check({where, " inst0"}, bus.inst_o[0], model_q[0]);
        if (sz >= 2) check({where, " inst1"}, bus.inst_o[1], model_q[1]);
    endtask

    task automatic step(input logic fl, input logic [1:0] pv, input logic [1:0] iss,
                        input logic st, input string where);
        inst_t a, b;
        int    sz, nv, n;
        bit    rdy;
        a = mk();
        b = mk();
        last_a              = a;
        bus.flush_i         = fl;
        bus.push_valid_i    = pv;
        bus.inst_i[0]       = a;
        bus.inst_i[1]       = b;
        bus.issue_num_i     = iss;
        bus.backend_stall_i = st;
        #1;
        check_model(where);
        sz  = model_q.size();
        nv  = (sz >= 2) ? 2 : sz;
        n   = (st || iss == 2'b11) ? 0 : int'(iss);
        if (n > nv) n = nv;
        rdy = (DEPTH - sz) >= 2;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            for (int i = 0; i < n; i++) void'(model_q.pop_front());
            if (rdy && pv[0]) model_q.push_back(a);
            if (rdy && pv[1]) model_q.push_back(b);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // fl, pv, iss, st, ready, valid (outputs seen before the edge)
        tbl[0]  = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 2'b00};
        tbl[1]  = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 2'b11};
        tbl[2]  = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 2'b11};
        tbl[3]  = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 2'b11};
        tbl[4]  = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b11};
        tbl[5]  = '{1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 2'b11};
        tbl[6]  = '{1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 2'b11};
        tbl[7]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b11};
        tbl[8]  = '{1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 2'b11};
        tbl[9]  = '{1'b1, 2'b11, 2'b10, 1'b0, 1'b1, 2'b11};
        tbl[10] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00};
        tbl[11] = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 2'b00};
        tbl[12] = '{1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 2'b11};
        tbl[13] = '{1'b0, 2'b10, 2'b10, 1'b1, 1'b1, 2'b11};
        tbl[14] = '{1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 2'b11};
        tbl[15] = '{1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 2'b11};
        tbl[16] = '{1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 2'b11};
        tbl[17] = '{1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 2'b01};
        tbl[18] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00};
        tbl[19] = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 2'b00};
        tbl[20] = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 2'b11};
        tbl[21] = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 2'b11};
        tbl[22] = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 2'b11};
        tbl[23] = '{1'b0, 2'b11, 2'b10, 1'b0, 1'b0, 2'b11};
        tbl[24] = '{1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 2'b11};
        tbl[25] = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 2'b11};
        tbl[26] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00};

        bus.flush_i         = 1'b0;
        bus.push_valid_i    = 2'b00;
        bus.inst_i          = '0;
        bus.issue_num_i     = 2'b00;
        bus.backend_stall_i = 1'b0;

        @(negedge clk);
        #1;
        check("reset ready", 64'(bus.push_ready_o), 64'd1);
        check("reset valid", 64'(bus.inst_valid_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            bus.push_valid_i = tbl[i].pv;
            #1;
            check($sformatf("tbl%0d ready", i), 64'(bus.push_ready_o), 64'(tbl[i].exp_ready));
            check($sformatf("tbl%0d valid", i), 64'(bus.inst_valid_o), 64'(tbl[i].exp_valid));
            #1;
            step(tbl[i].fl, tbl[i].pv, tbl[i].iss, tbl[i].st, $sformatf("tbl%0d", i));
        end

        // A,B,C buffered; issuing two leaves C alone at the head.
        step(1'b0, 2'b11, 2'b00, 1'b0, "abc push ab");
        step(1'b0, 2'b01, 2'b00, 1'b0, "abc push c");
        begin
            inst_t c_inst;
            c_inst = last_a;
            step(1'b0, 2'b00, 2'b10, 1'b0, "abc issue2");
            #1;
            check("abc head is c", bus.inst_o[0], c_inst);
            check("abc valid", 64'(bus.inst_valid_o), 64'(2'b01));
        end
        step(1'b0, 2'b00, 2'b01, 1'b0, "abc drain");

        // Asynchronous reset in the middle of a cycle empties the buffer at once.
        step(1'b0, 2'b11, 2'b00, 1'b0, "arst fill0");
        step(1'b0, 2'b11, 2'b00, 1'b0, "arst fill1");
        #2;
        rst_n = 1'b0;
        #1;
        check("arst valid", 64'(bus.inst_valid_o), 64'd0);
        check("arst ready", 64'(bus.push_ready_o), 64'd1);
        model_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 400; cyc++) begin
            int         sz, nv;
            logic [1:0] pv, iss;
            logic       st, fl;
            sz  = model_q.size();
            nv  = (sz >= 2) ? 2 : sz;
            pv  = 2'($urandom_range(0, 3));
            iss = 2'($urandom_range(0, nv));
            st  = ($urandom_range(0, 7) == 0);
            fl  = ($urandom_range(0, 99) == 0);
            step(fl, pv, iss, st, "rand");
        end

        for (int k = 0; k < 2 * DEPTH && model_q.size() > 0; k++) begin
            step(1'b0, 2'b00, (model_q.size() >= 2) ? 2'b10 : 2'b01, 1'b0, "drain");
        end
        step(1'b0, 2'b00, 2'b00, 1'b0, "empty");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
